accum_adder_seq: RTL and testbench

Sequential operand accumulator that sits directly upstream of the 32-bit ripple-carry adder's consumers. It accepts a stream of operands over a valid/ready handshake and adds each one, with its carry-in, into a running sum. It emits the group total and a sticky carry-out after `NUM_OPS` operands, or earlier when `in_last` is asserted. All addition uses one internal `WIDTH`-bit ripple-carry adder instance: operand a is the accumulator, operand b is `in_data`, cin is `in_cin`.

---
 rtl/accum_adder_seq.sv | 103 ++++++++++
 tb/tb_accum_adder_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/accum_adder_seq.sv
// Streaming operand accumulator: sums a group of operands through one ripple-carry adder
// and emits the total plus a sticky carry-out. Optional macro ACC_SATURATE_EN clamps on carry.
module accum_adder_seq #(
  parameter int WIDTH   = 32,
  parameter int NUM_OPS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_cin,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic [7:0]       out_count
);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             cflag_q, cflag_d;
  logic [7:0]       cnt_q, cnt_d;

  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic [7:0]       cnt_inc;

  // Single ripple-carry adder: operand a is the accumulator, b is the incoming operand.
  always_comb begin
    logic carry;
    carry = in_cin;
    for (int i = 0; i < WIDTH; i++) begin
      add_sum[i] = acc_q[i] ^ in_data[i] ^ carry;
      carry      = (acc_q[i] & in_data[i]) | (carry & (acc_q[i] ^ in_data[i]));
    end
    add_cout = carry;
  end

  assign cnt_inc = cnt_q + 8'd1;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cflag_d = cflag_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ACCUM: begin
        if (in_valid) begin
`ifdef ACC_SATURATE_EN
          acc_d = add_cout ? {WIDTH{1'b1}} : add_sum;
`else
          acc_d = add_sum;
`endif
          cflag_d = cflag_q | add_cout;
          cnt_d   = cnt_inc;
          if ((cnt_inc == 8'(NUM_OPS)) || in_last) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          acc_d   = '0;
          cflag_d = 1'b0;
          cnt_d   = 8'd0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cflag_q <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cflag_q <= cflag_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake flags decode the registered state only; no input-to-output path.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign out_sum   = acc_q;
  assign out_cout  = cflag_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_accum_adder_seq.sv
// Directed bench for accum_adder_seq: hand-computed group totals, backpressure and reset cases.
module tb_accum_adder_seq;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_cin;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic [7:0]       out_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  accum_adder_seq #(.WIDTH(WIDTH), .NUM_OPS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cin    (in_cin),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_count (out_count)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Present one operand and hold it until accepted (bounded), then drop in_valid.
  task automatic send_op(input logic [WIDTH-1:0] d, input logic c, input logic l);
    bit hs;
    hs = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_cin   = c;
    in_last  = l;
    for (int k = 0; k < 20 && !hs; k++) begin
      hs = in_ready;
      @(posedge clk);
      if (!hs) @(negedge clk);
    end
    #1 in_valid = 1'b0;
    check("handshake", 64'(hs), 64'd1);
  endtask

  // Result must appear right after the closing handshake and last one cycle (out_ready=1).
  task automatic expect_group(input string tag, input logic [WIDTH-1:0] sum,
                              input logic cout, input logic [7:0] cnt);
    @(negedge clk);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_sum"},   64'(out_sum), 64'(sum));
    check({tag, "_cout"},  64'(out_cout), 64'(cout));
    check({tag, "_count"}, 64'(out_count), 64'(cnt));
    @(negedge clk);
    check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_cnt_clr"},    64'(out_count), 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_cin    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready",  64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum",       64'(out_sum), 64'd0);
    check("rst_cout",      64'(out_cout), 64'd0);
    check("rst_count",     64'(out_count), 64'd0);

    // Full group of four plain operands.
    send_op(32'd1, 1'b0, 1'b0);
    send_op(32'd2, 1'b0, 1'b0);
    send_op(32'd3, 1'b0, 1'b0);
    #1 check("g1_no_early_valid", 64'(out_valid), 64'd0);
    send_op(32'd4, 1'b0, 1'b0);
    expect_group("g1", 32'd10, 1'b0, 8'd4);

    // Carry-ins; last operand closes on count and in_last together.
    send_op(32'd2,  1'b1, 1'b0);
    send_op(32'd5,  1'b0, 1'b0);
    send_op(32'd25, 1'b0, 1'b0);
    send_op(32'd30, 1'b1, 1'b1);
    expect_group("g2", 32'd64, 1'b0, 8'd4);

    // Wrap of the accumulator.
    send_op(32'hFFFF_FFFF, 1'b0, 1'b0);
    send_op(32'd1, 1'b0, 1'b0);
    send_op(32'd0, 1'b0, 1'b0);
    send_op(32'd0, 1'b0, 1'b0);
`ifdef ACC_SATURATE_EN
    expect_group("g3", 32'hFFFF_FFFF, 1'b1, 8'd4);
`else
    expect_group("g3", 32'h0000_0000, 1'b1, 8'd4);
`endif

    // Early close after two operands.
    send_op(32'd100, 1'b0, 1'b0);
    send_op(32'd200, 1'b1, 1'b1);
    expect_group("g4", 32'd301, 1'b0, 8'd2);

    // Backpressure in DONE with a waiting operand.
    out_ready = 1'b0;
    send_op(32'd7, 1'b0, 1'b0);
    send_op(32'd8, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'd50;
    in_cin   = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready",  64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_sum",       64'(out_sum), 64'd15);
      check("bp_count",     64'(out_count), 64'd2);
      @(negedge clk);
    end
    check("bp_cout", 64'(out_cout), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 64'(in_ready), 64'd1);
    check("bp_release_sum",   64'(out_sum), 64'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("bp_held_sum",   64'(out_sum), 64'd50);
    check("bp_held_count", 64'(out_count), 64'd1);
    send_op(32'd0, 1'b0, 1'b1);
    expect_group("g5", 32'd50, 1'b0, 8'd2);

    // Reset mid-group discards the partial sum.
    send_op(32'd15520, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready",  64'(in_ready), 64'd1);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_sum",       64'(out_sum), 64'd0);
    check("mid_rst_cout",      64'(out_cout), 64'd0);
    check("mid_rst_count",     64'(out_count), 64'd0);
    send_op(32'd35000, 1'b0, 1'b0);
    send_op(32'd0, 1'b0, 1'b1);
    expect_group("g6", 32'd35000, 1'b0, 8'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
